// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider and the execute-stage ALU:
// operand width, ALU opcodes, divider states and two's-complement helpers.
package alu_div_seq_pkg;

  localparam int DIV_W = 32;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] f_neg(input logic [DIV_W-1:0] v);
    return (~v) + {{(DIV_W-1){1'b0}}, 1'b1};
  endfunction

  // 32'h8000_0000 maps onto itself, which is the correct unsigned magnitude
  function automatic logic [DIV_W-1:0] f_abs(input logic [DIV_W-1:0] v);
    return v[DIV_W-1] ? f_neg(v) : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Execute-stage ALU (AND/OR/ADD/SUB/SLT). Under SUB, CarryOut is the unsigned
// borrow: set exactly when A < B.
module alu
  import alu_div_seq_pkg::*;
(
  input  logic [DIV_W-1:0] A,
  input  logic [DIV_W-1:0] B,
  input  logic [2:0]       ALUop,
  output logic [DIV_W-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  logic [DIV_W:0] w_sum;
  logic [DIV_W:0] w_diff;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    Result   = '0;
    CarryOut = 1'b0;
    Overflow = 1'b0;
    case (ALUop)
      ALU_OP_AND: Result = A & B;
      ALU_OP_OR:  Result = A | B;
      ALU_OP_ADD: begin
        Result   = w_sum[DIV_W-1:0];
        CarryOut = w_sum[DIV_W];
        Overflow = (A[DIV_W-1] == B[DIV_W-1]) && (w_sum[DIV_W-1] != A[DIV_W-1]);
      end
      ALU_OP_SUB: begin
        Result   = w_diff[DIV_W-1:0];
        CarryOut = w_diff[DIV_W];
        Overflow = (A[DIV_W-1] != B[DIV_W-1]) && (w_diff[DIV_W-1] != A[DIV_W-1]);
      end
      ALU_OP_SLT: Result = {{(DIV_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default:    Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_div_seq_div_sign_fix.sv
// Combinational sign handling for the divider: operand magnitudes at accept and
// result sign correction at completion. Present only when ALU_DIV_SIGNED_EN is defined.
`ifdef ALU_DIV_SIGNED_EN
module div_sign_fix
  import alu_div_seq_pkg::*;
(
  input  logic [DIV_W-1:0] i_dividend,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic [DIV_W-1:0] i_q_mag,
  input  logic [DIV_W-1:0] i_r_mag,
  input  logic             i_neg_q,
  input  logic             i_neg_r,
  output logic [DIV_W-1:0] o_dividend_mag,
  output logic [DIV_W-1:0] o_divisor_mag,
  output logic [DIV_W-1:0] o_quotient,
  output logic [DIV_W-1:0] o_remainder
);

  assign o_dividend_mag = f_abs(i_dividend);
  assign o_divisor_mag  = f_abs(i_divisor);
  assign o_quotient     = i_neg_q ? f_neg(i_q_mag) : i_q_mag;
  assign o_remainder    = i_neg_r ? f_neg(i_r_mag) : i_r_mag;

endmodule
`endif

// File: rtl/alu_div_seq.sv
// 32-bit restoring divider that borrows an external ALU for its per-bit subtract.
// Define ALU_DIV_SIGNED_EN for two's-complement operands (default: unsigned only).
module alu_div_seq
  import alu_div_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carryout
);

  div_state_e r_state, w_next_state;

  logic [DATA_WIDTH-1:0] r_q, r_r, r_div;
  logic [4:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_quotient, r_remainder;
  logic                  r_dbz;

  logic                  w_accept, w_div_zero, w_sub;
  logic [DATA_WIDTH-1:0] w_s, w_r_next, w_q_next, w_q_fin, w_r_fin;
  logic [DATA_WIDTH-1:0] w_dvd_mag, w_dvs_mag;

  assign w_accept   = (r_state == ST_IDLE) && in_valid;
  assign w_div_zero = (divisor == '0);
  assign w_s        = {r_r[DATA_WIDTH-2:0], r_q[DATA_WIDTH-1]};
  // r[31] set means the shifted value is really 33 bits, so it always exceeds the divisor
  assign w_sub      = r_r[DATA_WIDTH-1] | ~alu_carryout;
  assign w_r_next   = w_sub ? alu_result : w_s;
  assign w_q_next   = {r_q[DATA_WIDTH-2:0], w_sub};

`ifdef ALU_DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;

  div_sign_fix u_sign_fix (
    .i_dividend     (dividend),
    .i_divisor      (divisor),
    .i_q_mag        (w_q_next),
    .i_r_mag        (w_r_next),
    .i_neg_q        (r_neg_q),
    .i_neg_r        (r_neg_r),
    .o_dividend_mag (w_dvd_mag),
    .o_divisor_mag  (w_dvs_mag),
    .o_quotient     (w_q_fin),
    .o_remainder    (w_r_fin)
  );

  // Sign flags captured at accept for the final correction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
      r_neg_r <= dividend[DATA_WIDTH-1];
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_fin   = w_q_next;
  assign w_r_fin   = w_r_next;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_next_state = w_div_zero ? ST_DONE : ST_CALC;
        else          w_next_state = ST_IDLE;
      end
      ST_CALC: begin
        if (r_cnt == 5'd0) w_next_state = ST_DONE;
        else               w_next_state = ST_CALC;
      end
      ST_DONE: begin
        if (out_ready) w_next_state = ST_IDLE;
        else           w_next_state = ST_DONE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Working registers and result capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q         <= '0;
      r_r         <= '0;
      r_div       <= '0;
      r_cnt       <= 5'd0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_q   <= w_dvd_mag;
      r_r   <= '0;
      r_div <= w_dvs_mag;
      r_cnt <= 5'd31;
      if (w_div_zero) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end
    end else if (r_state == ST_CALC) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) begin
        r_quotient  <= w_q_fin;
        r_remainder <= w_r_fin;
        r_dbz       <= 1'b0;
      end
    end
  end

  // ALU operands are only presented while iterating
  always_comb begin
    alu_A = '0;
    alu_B = '0;
    if (r_state == ST_CALC) begin
      alu_A = w_s;
      alu_B = r_div;
    end else begin
      alu_A = '0;
      alu_B = '0;
    end
  end

  assign alu_op      = ALU_OP_SUB;
  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq driving the real alu; vector table,
// hand-written timing sequences and randomized operations against a reference model.
module tb_alu_div_seq;
  import alu_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        in_ready, out_valid, div_by_zero;
  logic [31:0] quotient, remainder, alu_A, alu_B, alu_result;
  logic [2:0]  alu_op;
  logic        alu_carryout, alu_ovf, alu_zero;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_div_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  alu u_alu (
    .A(alu_A), .B(alu_B), .ALUop(alu_op),
    .Result(alu_result), .CarryOut(alu_carryout),
    .Overflow(alu_ovf), .Zero(alu_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Reference: quotient/remainder straight from integer division of the magnitudes
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    logic [31:0] ma, mb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      ma = a[31] ? (32'd0 - a) : a;
      mb = b[31] ? (32'd0 - b) : b;
      q = ma / mb;
      r = ma % mb;
      if (a[31] != b[31]) q = 32'd0 - q;
      if (a[31]) r = 32'd0 - r;
`else
      ma = a; mb = b;
      q = ma / mb;
      r = ma % mb;
`endif
    end
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v);
`ifdef ALU_DIV_SIGNED_EN
    return v[31] ? (32'd0 - v) : v;
`else
    return v;
`endif
  endfunction

  // Issue one operation; returns at the negedge where out_valid is first seen
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat);
    int guard = 0;
    @(negedge clk);
    dividend = a; divisor = b; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(negedge clk);
      if (out_valid) break;
      if (lat == 1) begin
        check("calc_alu_B", alu_B, mag(b));
        check("calc_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      lat++;
    end
    check("out_valid_reached", {31'd0, out_valid}, 32'd1);
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  logic [31:0] gq, gr, eq, er;
  logic        gz, ez;
  int          lat;
  int          seen;
  logic [31:0] ra, rb;

  initial begin
    vecs.push_back('{32'd100,  32'd7,  32'd14,        32'd2,    1'b0});
    vecs.push_back('{32'd1234, 32'd0,  32'hFFFF_FFFF, 32'd1234, 1'b1});
    vecs.push_back('{32'd9,    32'd4,  32'd2,         32'd1,    1'b0});
    vecs.push_back('{32'd0,    32'd5,  32'd0,         32'd0,    1'b0});
    vecs.push_back('{32'd5,    32'd10, 32'd0,         32'd5,    1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0});
`ifdef ALU_DIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0});
    vecs.push_back('{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1});
`else
    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0});
`endif

    // Reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd6);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Vector table, consumed immediately
    for (int i = 0; i < vecs.size(); i++) begin
      run_div(vecs[i].a, vecs[i].b, gq, gr, gz, lat);
      check($sformatf("vec%0d_quotient", i), gq, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), gr, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), {31'd0, gz}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].b == 32'd0) ? 32'd1 : 32'd33);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready_after", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("vec%0d_idle_alu_A", i), alu_A, 32'd0);
    end

    // Back-pressure: outputs frozen while out_ready is low
    out_ready = 1'b0;
    run_div(32'd50, 32'd5, gq, gr, gz, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_quotient", quotient, 32'd10);
      check("bp_remainder", remainder, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of 1000 / 3
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_in_ready_busy", {31'd0, in_ready}, 32'd0);
    resetn = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    check("mid_rst_alu_A", alu_A, 32'd0);
    check("mid_rst_alu_B", alu_B, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_no_out_valid", seen, 32'd0);
    check("mid_in_ready_idle", {31'd0, in_ready}, 32'd1);
    run_div(32'd9, 32'd4, gq, gr, gz, lat);
    check("post_rst_quotient", gq, 32'd2);
    check("post_rst_remainder", gr, 32'd1);
    @(posedge clk);

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom;
        3:       rb = {1'b1, 31'($urandom)};
        default: rb = 32'($urandom_range(1, 300));
      endcase
      model(ra, rb, eq, er, ez);
      run_div(ra, rb, gq, gr, gz, lat);
      check($sformatf("rnd%0d_quotient %h/%h", n, ra, rb), gq, eq);
      check($sformatf("rnd%0d_remainder %h/%h", n, ra, rb), gr, er);
      check($sformatf("rnd%0d_dbz", n), {31'd0, gz}, {31'd0, ez});
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
